// File: rtl/input_unit.sv
// rtl/input_unit.sv - router input port: flit FIFO, routing request and switch-allocation sequencing
//
// Purpose: buffers single-flit packets from upstream, asks the routing computer
// for an output mask for the head flit, requests the switch for every port in
// that mask, and returns one credit upstream per flit leaving the buffer.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   in_valid/in_data upstream flit, written when the buffer has room
//   credit_out       one-cycle pulse, one per dequeued flit
//   rc_en            high for the single RC cycle of each head flit
//   rc_direction     this unit's input port (parameter)
//   rc_route_info/rc_route_addr  routing fields of the head flit
//   route_port       output mask from the routing computer (combinational)
//   sa_req/sa_grant  per-output-port switch request / grant
//   out_data         head flit presented to the crossbar
//   drop_pulse       head flit discarded because its mask was empty
//   overflow         sticky: a flit arrived while the buffer was full

`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 2
`endif
`ifndef ROUTER_ADDR_WIDTH
`define ROUTER_ADDR_WIDTH 4
`endif
`ifndef ROUTER_DATA_WIDTH
`define ROUTER_DATA_WIDTH 8
`endif
`ifndef DIRECTION
`define DIRECTION 5
`endif
`ifndef DIR_WIDTH
`define DIR_WIDTH 3
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 3'd4
`endif

module input_unit #(
  parameter logic [`DIR_WIDTH-1:0] direction = `DIR_LOCAL,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [`ROUTER_INFO_WIDTH+`ROUTER_ADDR_WIDTH+`ROUTER_DATA_WIDTH-1:0] in_data,
  output logic                                credit_out,
  output logic                                rc_en,
  output logic [`DIR_WIDTH-1:0]               rc_direction,
  output logic [`ROUTER_INFO_WIDTH-1:0]       rc_route_info,
  output logic [`ROUTER_ADDR_WIDTH-1:0]       rc_route_addr,
  input  logic [`DIRECTION-1:0]               route_port,
  output logic [`DIRECTION-1:0]               sa_req,
  input  logic [`DIRECTION-1:0]               sa_grant,
  output logic [`ROUTER_INFO_WIDTH+`ROUTER_ADDR_WIDTH+`ROUTER_DATA_WIDTH-1:0] out_data,
  output logic                                drop_pulse,
  output logic                                overflow
);

  localparam int FLIT_W = `ROUTER_INFO_WIDTH + `ROUTER_ADDR_WIDTH + `ROUTER_DATA_WIDTH;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RC, SA} state_t;

  logic [FLIT_W-1:0]     mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [`DIRECTION-1:0] pending;
  logic [`DIRECTION-1:0] pending_next;
  logic [FLIT_W-1:0]     head;
  state_t                state;

  logic full;
  logic wr_en;
  logic drop;
  logic sa_done;
  logic deq;

  // Fullness uses the pre-edge count, so a full buffer refuses a write even
  // when the head leaves on the same edge.
  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign wr_en   = in_valid && !full;

  // Grant bits outside the pending mask fall away in the AND.
  assign pending_next = pending & ~sa_grant;
  assign drop    = (state == RC) && (route_port == '0);
  assign sa_done = (state == SA) && (pending_next == '0);
  assign deq     = drop || sa_done;

  assign head          = mem[rd_ptr];
  assign out_data      = head;
  assign rc_route_info = head[FLIT_W-1 -: `ROUTER_INFO_WIDTH];
  assign rc_route_addr = head[FLIT_W-`ROUTER_INFO_WIDTH-1 -: `ROUTER_ADDR_WIDTH];
  assign rc_direction  = direction;
  assign drop_pulse    = drop;

  // pending is non-zero only while in SA, so it doubles as the request vector.
  assign sa_req = pending;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      credit_out <= 1'b0;
      rc_en      <= 1'b0;
      state      <= IDLE;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq)   rd_ptr <= rd_ptr + PTR_W'(1);

      case ({wr_en, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      credit_out <= deq;
      if (in_valid && full) overflow <= 1'b1;

      rc_en <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= RC;
            rc_en <= 1'b1;
          end
        end
        RC: begin
          if (drop) begin
            state <= IDLE;
          end else begin
            pending <= route_port;
            state   <= SA;
          end
        end
        SA: begin
          pending <= pending_next;
          if (pending_next == '0) state <= IDLE;
        end
        default: begin
          pending <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/input_unit.md
INPUT_UNIT -- requirements
Module: input_unit

Interface
REQ-001 Parameter: direction, default `DIR_LOCAL, input port this unit serves; forwarded unchanged to the routing computer.
REQ-002 Parameter: BUF_DEPTH, default 4, flit buffer depth; legal values are powers of two, 2..16.
REQ-003 Flit format: in_data = {route_info[`ROUTER_INFO_WIDTH], route_addr[`ROUTER_ADDR_WIDTH], payload[`ROUTER_DATA_WIDTH]}, MSB first, single-flit packets; FLIT_W is the sum of the three widths.
REQ-004 clk  input  1  sole clock, all state rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream flit present on in_data this cycle.
REQ-007 in_data  input  FLIT_W  incoming flit.
REQ-008 credit_out  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-009 rc_en  output  1  routing enable to the routing computer.
REQ-010 rc_direction  output  `DIR_WIDTH  equals parameter direction, constant.
REQ-011 rc_route_info  output  `ROUTER_INFO_WIDTH  head-flit route_info.
REQ-012 rc_route_addr  output  `ROUTER_ADDR_WIDTH  head-flit route_addr.
REQ-013 route_port  input  `DIRECTION  one-hot or multicast port mask returned combinationally by the routing computer.
REQ-014 sa_req  output  `DIRECTION  per-output-port switch requests.
REQ-015 sa_grant  input  `DIRECTION  per-output-port grants, valid in the same cycle as sa_req.
REQ-016 out_data  output  FLIT_W  head flit presented to the crossbar.
REQ-017 drop_pulse  output  1  one-cycle pulse when the head flit is discarded as unroutable.
REQ-018 overflow  output  1  sticky flag set when a flit arrives while the buffer is full.

Function
REQ-019 The buffer is a circular FIFO with read/write pointers and a count of width clog2(BUF_DEPTH)+1; pointers wrap from BUF_DEPTH-1 to 0.
REQ-020 When in_valid=1 and count<BUF_DEPTH at the rising edge, the unit writes in_data; fullness is judged on the pre-edge count, so a write while full is dropped even when a dequeue occurs in the same cycle, and overflow is set to 1.
REQ-021 A simultaneous write and dequeue leaves the count unchanged.
REQ-022 FSM states are IDLE, RC and SA; the reset state is IDLE.
REQ-023 IDLE: if count>0, the FSM moves to RC at the next edge; otherwise it stays in IDLE.
REQ-024 RC: rc_en=1 for exactly this one cycle, and rc_route_info/rc_route_addr come from the head flit.
REQ-025 RC with route_port!=0: route_port is latched into a pending mask and the FSM moves to SA.
REQ-026 RC with route_port==0: the head flit is dequeued, drop_pulse=1 in this cycle, credit_out is pulsed and the FSM returns to IDLE.
REQ-027 SA: sa_req=pending, out_data=head flit, and pending is updated to pending & ~sa_grant at each edge; grant bits outside pending are ignored.
REQ-028 SA completes when (pending & ~sa_grant)==0, including when all multicast grants arrive in one cycle; at that edge the head flit is dequeued and the FSM returns to IDLE.
REQ-029 credit_out is registered and pulses for one cycle in the cycle after each dequeue, whether the flit was forwarded or dropped.
REQ-030 Outside RC, rc_en=0; outside SA, sa_req=0; rc_route_info, rc_route_addr and out_data always reflect the head entry.
REQ-031 Minimum latency: a flit written at edge t into an empty, idle unit drives rc_en in cycle t+1 to t+2 (RC), raises sa_req from cycle t+2 onward, and is dequeued at the first edge where the completion condition holds.
REQ-032 Back-to-back flits each take at least 3 cycles: one each in IDLE, RC and SA.

Reset
REQ-033 rst=0 asynchronously clears the pointers, count, pending mask and overflow, forces the FSM to IDLE, and drives credit_out, rc_en, sa_req and drop_pulse to 0.
REQ-034 Buffer contents are not reset, and a reset mid-packet discards all buffered flits without issuing credits.
REQ-035 Operation resumes on the first clock edge after rst returns to 1.

Verification
REQ-036 Unicast: one flit with CONFIG info and route_port=5'b00100 -> rc_en for 1 cycle, sa_req=5'b00100 until granted, dequeue, credit_out pulse 1 cycle later.
REQ-037 Multicast: route_port=5'b01111 with grants 0001, then 0110, then 1000 -> sa_req goes 1111, 1110, 1000, and the flit dequeues only on the third grant; exactly one credit is returned.
REQ-038 Unroutable: route_port=0 -> drop_pulse for 1 cycle, no sa_req, and one credit is returned.
REQ-039 Full: write BUF_DEPTH+1 flits with no grants -> the last flit is dropped, overflow=1 and count=BUF_DEPTH; draining then returns exactly BUF_DEPTH credits in FIFO order.
REQ-040 Wrap: stream 3*BUF_DEPTH flits with immediate grants -> in-order out_data across pointer wrap, and the unit never overflows.
REQ-041 Reset in SA with 2 flits buffered -> outputs 0 immediately, count=0, and no credits are issued.
